// File: rtl/wb_sha_bridge.sv
// Wishbone slave bridging the user bus to NUM_CORES SHA-256 cores, with a local
// ID/CTRL/STATUS page, sticky error capture and a registered interrupt.
module wb_sha_bridge #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned READ_LAT  = 1,
  parameter logic [7:0]  BASE_HI   = 8'h30
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [NUM_CORES-1:0]    core_cs,
  output logic                    core_we,
  output logic [ADDR_W-1:0]       core_address,
  output logic [31:0]             core_write_data,
  input  logic [32*NUM_CORES-1:0] core_read_data,
  input  logic [NUM_CORES-1:0]    core_error,
  output logic                    clk_sel,
  output logic                    irq_o
);

  localparam logic [7:0]  EnMask   = 8'((32'd1 << NUM_CORES) - 32'd1);
  localparam logic [1:0]  WaitInit = 2'(READ_LAT - 1);
  localparam logic [31:0] IdWord   = {8'hB1, 8'(NUM_CORES), 16'h0001};

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StAck} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [3:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic              base_ok_q, base_ok_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [7:0]        irq_en_q, irq_en_d;
  logic              clk_sel_q, clk_sel_d;
  logic              dec_err_q, dec_err_d;
  logic              sel_err_q, sel_err_d;
  logic              irq_q;

  logic        core_hit, local_hit, sel_bad, issue;
  logic        set_dec, set_sel, clr_dec, clr_sel;
  logic [7:0]  err_live;
  logic [31:0] core_rdata, local_rdata;

  // Address bits outside the decoded fields are intentionally ignored.
  logic unused_adr;
  assign unused_adr = ^{wbs_adr_i[23:ADDR_W+6], wbs_adr_i[1:0]};

  assign err_live  = 8'(core_error);
  assign core_hit  = base_ok_q && (32'(idx_q) < NUM_CORES);
  assign local_hit = base_ok_q && (idx_q == 4'd8);
  assign sel_bad   = core_hit && we_q && (sel_q != 4'hF);
  assign issue     = (state_q == StAccess) && core_hit && !sel_bad;

  always_comb begin
    core_cs    = '0;
    core_rdata = '0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      core_cs[i] = issue && (idx_q == 4'(i));
      if (idx_q == 4'(i)) core_rdata = core_read_data[32*i +: 32];
    end
  end

  assign core_we         = issue && we_q;
  assign core_address    = issue ? off_q : '0;
  assign core_write_data = issue ? wdata_q : '0;

  always_comb begin
    local_rdata = '0;
    if (off_q == ADDR_W'(0)) local_rdata = IdWord;
    else if (off_q == ADDR_W'(1)) local_rdata = {15'b0, clk_sel_q, 8'b0, irq_en_q};
    else if (off_q == ADDR_W'(2)) local_rdata = {sel_err_q, dec_err_q, 22'b0, err_live};
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    sel_d     = sel_q;
    idx_d     = idx_q;
    off_d     = off_q;
    base_ok_d = base_ok_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    irq_en_d  = irq_en_q;
    clk_sel_d = clk_sel_q;
    set_dec   = 1'b0;
    set_sel   = 1'b0;
    clr_dec   = 1'b0;
    clr_sel   = 1'b0;
    unique case (state_q)
      StIdle: begin
        rdata_d = '0;
        if (wbs_cyc_i && wbs_stb_i) begin
          we_d      = wbs_we_i;
          sel_d     = wbs_sel_i;
          idx_d     = wbs_adr_i[ADDR_W+5:ADDR_W+2];
          off_d     = wbs_adr_i[ADDR_W+1:2];
          base_ok_d = (wbs_adr_i[31:24] == BASE_HI);
          wdata_d   = wbs_dat_i;
          state_d   = StAccess;
        end
      end
      StAccess: begin
        if (!wbs_cyc_i) begin
          state_d = StIdle;
        end else if (core_hit && !we_q) begin
          cnt_d   = WaitInit;
          state_d = StWait;
        end else begin
          state_d = StAck;
          rdata_d = (local_hit && !we_q) ? local_rdata : '0;
          set_dec = !core_hit && !local_hit;
          set_sel = sel_bad;
          if (local_hit && we_q) begin
            if (off_q == ADDR_W'(1)) begin
              if (sel_q[0]) irq_en_d = wdata_q[7:0] & EnMask;
              if (sel_q[2]) clk_sel_d = wdata_q[16];
            end else if (off_q == ADDR_W'(2)) begin
              clr_dec = wdata_q[30];
              clr_sel = wdata_q[31];
            end
          end
        end
      end
      StWait: begin
        if (!wbs_cyc_i) begin
          state_d = StIdle;
        end else if (cnt_q == 2'd0) begin
          rdata_d = core_rdata;
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A coincident set dominates the write-one-to-clear.
    dec_err_d = set_dec | (dec_err_q & ~clr_dec);
    sel_err_d = set_sel | (sel_err_q & ~clr_sel);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      we_q      <= 1'b0;
      sel_q     <= '0;
      idx_q     <= '0;
      off_q     <= '0;
      base_ok_q <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      irq_en_q  <= '0;
      clk_sel_q <= 1'b0;
      dec_err_q <= 1'b0;
      sel_err_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      off_q     <= off_d;
      base_ok_q <= base_ok_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      irq_en_q  <= irq_en_d;
      clk_sel_q <= clk_sel_d;
      dec_err_q <= dec_err_d;
      sel_err_q <= sel_err_d;
      irq_q     <= (|(err_live & irq_en_q)) | dec_err_q | sel_err_q;
    end
  end

  assign wbs_ack_o = (state_q == StAck);
  assign wbs_dat_o = wbs_ack_o ? rdata_q : '0;
  assign clk_sel   = clk_sel_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_sha_bridge.sv
// Directed plus randomized bench for wb_sha_bridge against a transaction-level
// model of the bus map, control register and sticky status bits.
module tb_wb_sha_bridge;
  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        rst, cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic        ack, core_we, clk_sel, irq;
  logic [31:0] dat_o, core_wdata;
  logic [1:0]  core_cs, core_err;
  logic [7:0]  core_address;
  logic [31:0] crd [2];
  logic [63:0] core_rd_bus;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: CTRL fields and sticky STATUS bits.
  logic [7:0] m_en;
  logic       m_clk, m_dec, m_sel;

  assign core_rd_bus = {crd[1], crd[0]};

  always #5 clk = ~clk;

  wb_sha_bridge #(
    .NUM_CORES (2),
    .ADDR_W    (8),
    .READ_LAT  (RL),
    .BASE_HI   (8'h30)
  ) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .wbs_cyc_i       (cyc),
    .wbs_stb_i       (stb),
    .wbs_we_i        (we),
    .wbs_sel_i       (sel),
    .wbs_adr_i       (adr),
    .wbs_dat_i       (dat_i),
    .wbs_ack_o       (ack),
    .wbs_dat_o       (dat_o),
    .core_cs         (core_cs),
    .core_we         (core_we),
    .core_address    (core_address),
    .core_write_data (core_wdata),
    .core_read_data  (core_rd_bus),
    .core_error      (core_err),
    .clk_sel         (clk_sel),
    .irq_o           (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic w,
                      input logic [3:0] s, output logic [31:0] rd, output int lat,
                      output int cs_cnt, output logic [1:0] cs_v, output logic cwe,
                      output logic [7:0] caddr, output logic [31:0] cwd,
                      output logic leak);
    rd = '0; cs_cnt = 0; cs_v = '0; cwe = 1'b0; caddr = '0; cwd = '0; leak = 1'b0;
    lat = -1;
    @(posedge clk); #1;
    adr = a; dat_i = d; we = w; sel = s; cyc = 1'b1; stb = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (core_cs !== 2'b00) begin
        cs_cnt++; cs_v = core_cs; cwe = core_we; caddr = core_address; cwd = core_wdata;
      end
      if (ack === 1'b1) begin
        rd = dat_o; lat = c;
        break;
      end
      if (dat_o !== 32'h0) leak = 1'b1;
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  function automatic logic exp_irq();
    return (|({6'b0, core_err} & m_en)) | m_dec | m_sel;
  endfunction

  // One transaction checked against the bus-map model.
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic w, input logic [3:0] s);
    int unsigned idx, off;
    logic        base_ok;
    logic [31:0] e_rd, rd, cwd;
    int          e_lat, e_cnt, lat, cs_cnt;
    logic [1:0]  cs_v;
    logic        cwe, leak;
    logic [7:0]  caddr;
    idx = (a >> 10) & 15;
    off = (a >> 2) & 255;
    base_ok = ((a >> 24) == 32'h30);
    e_rd = '0; e_lat = 2; e_cnt = 0;
    if (!base_ok || (idx >= 2 && idx != 8)) begin
      m_dec = 1'b1;
    end else if (idx < 2) begin
      if (w && s != 4'hF) m_sel = 1'b1;
      else e_cnt = 1;
      if (!w) begin
        e_lat = 2 + RL;
        e_rd  = crd[idx];
      end
    end else if (w) begin
      if (off == 1) begin
        if (s[0]) m_en = d[7:0] & 8'h03;
        if (s[2]) m_clk = d[16];
      end else if (off == 2) begin
        if (d[30]) m_dec = 1'b0;
        if (d[31]) m_sel = 1'b0;
      end
    end else begin
      case (off)
        0: e_rd = 32'hB102_0001;
        1: e_rd = {15'b0, m_clk, 8'b0, m_en};
        2: e_rd = {m_sel, m_dec, 28'b0, core_err};
        default: e_rd = '0;
      endcase
    end
    xfer(a, d, w, s, rd, lat, cs_cnt, cs_v, cwe, caddr, cwd, leak);
    check({tag, ".lat"}, 32'(lat), 32'(e_lat));
    check({tag, ".rdata"}, rd, e_rd);
    check({tag, ".cs_pulses"}, 32'(cs_cnt), 32'(e_cnt));
    check({tag, ".dat_off_ack"}, {31'b0, leak}, 32'h0);
    if (e_cnt == 1) begin
      check({tag, ".cs"}, {30'b0, cs_v}, 32'(1 << idx));
      check({tag, ".cwe"}, {31'b0, cwe}, {31'b0, w});
      check({tag, ".caddr"}, {24'b0, caddr}, off);
      check({tag, ".cwdata"}, cwd, w ? d : 32'h0);
    end
    @(negedge clk);
    check({tag, ".ack_1cyc"}, {31'b0, ack}, 32'h0);
    check({tag, ".dat_after"}, dat_o, 32'h0);
    check({tag, ".irq"}, {31'b0, irq}, {31'b0, exp_irq()});
    check({tag, ".clk_sel"}, {31'b0, clk_sel}, {31'b0, m_clk});
  endtask

  initial begin
    logic [31:0] a;
    logic        acked;
    int          kind, idx;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_i = '0;
    core_err = 2'b00; crd[0] = '0; crd[1] = '0;
    m_en = '0; m_clk = 1'b0; m_dec = 1'b0; m_sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.ack", {31'b0, ack}, 32'h0);
    check("rst.dat", dat_o, 32'h0);
    check("rst.cs", {30'b0, core_cs}, 32'h0);
    check("rst.clk_sel", {31'b0, clk_sel}, 32'h0);
    check("rst.irq", {31'b0, irq}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    run("wr_core1", 32'h3000_0414, 32'hA5A5_0001, 1'b1, 4'hF);
    crd[0] = 32'h6A09_E667;
    run("rd_core0", 32'h3000_0008, 32'h0, 1'b0, 4'hF);
    run("sel_err", 32'h3000_0004, 32'h1234_5678, 1'b1, 4'h3);
    run("st_sel", 32'h3000_2008, 32'h0, 1'b0, 4'hF);
    run("st_clr", 32'h3000_2008, 32'h8000_0000, 1'b1, 4'hF);
    run("st_zero", 32'h3000_2008, 32'h0, 1'b0, 4'hF);
    run("dec_err", 32'h3000_0C00, 32'h0, 1'b0, 4'hF);
    run("st_dec", 32'h3000_2008, 32'h0, 1'b0, 4'hF);
    run("st_clr2", 32'h3000_2008, 32'h4000_0000, 1'b1, 4'hF);
    run("id", 32'h3000_2000, 32'h0, 1'b0, 4'hF);
    run("ctrl_wr", 32'h3000_2004, 32'h0001_0002, 1'b1, 4'hF);
    run("ctrl_rd", 32'h3000_2004, 32'h0, 1'b0, 4'hF);
    core_err = 2'b10;
    repeat (2) @(negedge clk);
    check("irq_core1", {31'b0, irq}, 32'h1);
    core_err = 2'b01;
    repeat (2) @(negedge clk);
    check("irq_core0_masked", {31'b0, irq}, 32'h0);

    // Abort a core read while waiting for data.
    @(posedge clk); #1;
    adr = 32'h3000_0400; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    acked = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack === 1'b1) acked = 1'b1;
    end
    check("abort.no_ack", {31'b0, acked}, 32'h0);
    crd[1] = 32'hBB67_AE85;
    run("after_abort", 32'h3000_0400, 32'h0, 1'b0, 4'hF);

    // Reset while a core write is in its access cycle.
    @(posedge clk); #1;
    adr = 32'h3000_0010; dat_i = 32'hDEAD_BEEF; we = 1'b1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    check("rstmid.cs_live", {30'b0, core_cs}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstmid.ack", {31'b0, ack}, 32'h0);
    check("rstmid.dat", dat_o, 32'h0);
    check("rstmid.cs", {30'b0, core_cs}, 32'h0);
    check("rstmid.cwe", {31'b0, core_we}, 32'h0);
    check("rstmid.caddr", {24'b0, core_address}, 32'h0);
    check("rstmid.cwdata", core_wdata, 32'h0);
    check("rstmid.clk_sel", {31'b0, clk_sel}, 32'h0);
    check("rstmid.irq", {31'b0, irq}, 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    m_en = '0; m_clk = 1'b0; m_dec = 1'b0; m_sel = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    for (int n = 0; n < 60; n++) begin
      crd[0]   = $urandom;
      crd[1]   = $urandom;
      core_err = 2'($urandom_range(0, 3));
      kind     = $urandom_range(0, 6);
      idx      = $urandom_range(0, 1);
      a = {8'h30, 10'b0, 4'(idx), 8'($urandom_range(0, 255)), 2'b00};
      case (kind)
        0: run("rnd_cwr", a, $urandom, 1'b1, 4'hF);
        1: run("rnd_cwr_sel", a, $urandom, 1'b1, 4'($urandom_range(0, 15)));
        2: run("rnd_crd", a, 32'h0, 1'b0, 4'($urandom_range(0, 15)));
        3: run("rnd_lrd", {8'h30, 10'b0, 4'd8, 8'($urandom_range(0, 4)), 2'b00}, 32'h0,
               1'b0, 4'hF);
        4: run("rnd_lwr", {8'h30, 10'b0, 4'd8, 8'($urandom_range(1, 3)), 2'b00}, $urandom,
               1'b1, 4'($urandom_range(0, 15)));
        5: run("rnd_badidx", {8'h30, 10'b0, 4'($urandom_range(2, 7)), 8'h00, 2'b00},
               $urandom, 1'($urandom_range(0, 1)), 4'hF);
        default: run("rnd_badbase", {8'($urandom_range(0, 47)), a[23:0]}, $urandom,
                     1'($urandom_range(0, 1)), 4'hF);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
